// File: rtl/tc_clk_mux_2.sv
// Technology-cell wrapper: 2:1 mux for clock/reset-class nets, glitch-free on
// equal data inputs, with an optional clk_i-domain synchronizer on the select.
module tc_clk_mux_2 #(
    parameter bit          SyncSel    = 1'b0,
    parameter int unsigned SyncStages = 32'd2
) (
    input  logic clk_i     = 1'b0,
    input  logic rst_ni    = 1'b1,
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o,
    output logic sel_o
);

    logic sel_eff_s;

`ifndef SYNTHESIS
    if (SyncSel && (SyncStages < 32'd2)) begin : gen_param_check
        $fatal(1, "tc_clk_mux_2: SyncStages must be at least 2 when SyncSel=1");
    end
`endif

    if (SyncSel) begin : gen_sync_sel
        logic [SyncStages-1:0] sync_r;

        // Select synchronizer shift register; reset forces clk0_i selection at once.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_r <= {SyncStages{1'b0}};
            end else begin
                sync_r <= {sync_r[SyncStages-2:0], clk_sel_i};
            end
        end

        assign sel_eff_s = sync_r[SyncStages-1];
    end else begin : gen_comb_sel
        // Purely combinational select: clock and reset are intentionally unused.
        logic unused_s;
        assign unused_s  = ^{clk_i, rst_ni};
        assign sel_eff_s = clk_sel_i;
    end

    // Equal inputs short-circuit the select so an unknown select cannot leak
    // onto a reset tree; otherwise a plain ternary keeps X on an X select.
    assign clk_o = (clk0_i == clk1_i) ? clk0_i : (sel_eff_s ? clk1_i : clk0_i);
    assign sel_o = sel_eff_s;

endmodule

// File: tb/tb_tc_clk_mux_2.sv
// Directed self-checking bench for tc_clk_mux_2 in combinational and
// synchronized-select configurations.
module tb_tc_clk_mux_2;

    logic clk;
    logic clk_en;
    logic rst_n;

    logic a0, a1, asel, c_clk, c_sel;
    logic b0, b1, bsel, s_clk, s_sel;

    int tests;
    int fails;

    tc_clk_mux_2 #(.SyncSel(1'b0), .SyncStages(32'd2)) u_comb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clk0_i    (a0),
        .clk1_i    (a1),
        .clk_sel_i (asel),
        .clk_o     (c_clk),
        .sel_o     (c_sel)
    );

    tc_clk_mux_2 #(.SyncSel(1'b1), .SyncStages(32'd2)) u_sync (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clk0_i    (b0),
        .clk1_i    (b1),
        .clk_sel_i (bsel),
        .clk_o     (s_clk),
        .sel_o     (s_sel)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic r;
        tests  = 0;
        fails  = 0;
        clk_en = 1'b1;
        rst_n  = 1'b0;
        a0 = 1'b0; a1 = 1'b1; asel = 1'b0;
        b0 = 1'b0; b1 = 1'b1; bsel = 1'b1;

        // Reset state of the synchronized mux
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", s_sel, 1'b0);
        check("rst_clk0_lo", s_clk, 1'b0);
        b0 = 1'b1; #1;
        check("rst_clk0_hi", s_clk, 1'b1);
        b0 = 1'b0; #1;

        // Combinational select toggling
        asel = 1'b0; #1; check("comb_sel0", c_clk, 1'b0);
        asel = 1'b1; #1; check("comb_sel1", c_clk, 1'b1);
        check("comb_selo1", c_sel, 1'b1);
        asel = 1'b0; #1; check("comb_sel0b", c_clk, 1'b0);
        check("comb_selo0", c_sel, 1'b0);
        asel = 1'b1; a1 = 1'b0; #1; check("comb_clk1_lo", c_clk, 1'b0);
        a1 = 1'b1; #1; check("comb_clk1_hi", c_clk, 1'b1);

        // Reset bypass: tie-off wins, then clk0 is tracked
        for (int i = 0; i < 8; i++) begin
            r = 1'($urandom_range(0, 1));
            a0 = r; #1;
            check("bypass_tie", c_clk, 1'b1);
        end
        asel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = 1'($urandom_range(0, 1));
            a0 = r; #1;
            check("bypass_track", c_clk, r);
        end

        // Equal inputs with unknown select
        a0 = 1'b1; a1 = 1'b1; asel = 1'bx; #1; check("eq_ones", c_clk, 1'b1);
        a0 = 1'b0; a1 = 1'b0; #1; check("eq_zeros", c_clk, 1'b0);
        asel = 1'b0;

        // Synchronized select latency
        bsel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sync_idle", s_sel, 1'b0);
        bsel = 1'b1; #1;
        check("sync_edge0", s_sel, 1'b0);
        @(posedge clk); #1;
        check("sync_edge1_sel", s_sel, 1'b0);
        check("sync_edge1_clk", s_clk, 1'b0);
        @(posedge clk); #1;
        check("sync_edge2_sel", s_sel, 1'b1);
        check("sync_edge2_clk", s_clk, 1'b1);

        // Asynchronous reset between edges
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("arst_sel", s_sel, 1'b0);
        check("arst_clk_lo", s_clk, 1'b0);
        b0 = 1'b1; #1;
        check("arst_clk_hi", s_clk, 1'b1);
        b0 = 1'b0;
        rst_n = 1'b1; #1;
        check("arel_now", s_sel, 1'b0);
        @(posedge clk); #1;
        check("arel_edge1", s_sel, 1'b0);
        @(posedge clk); #1;
        check("arel_edge2", s_sel, 1'b1);

        // Clock stopped: data paths stay live, select stays frozen
        clk_en = 1'b0;
        #20;
        b1 = 1'b0; #1; check("stop_clk1_lo", s_clk, 1'b0);
        b1 = 1'b1; #1; check("stop_clk1_hi", s_clk, 1'b1);
        b0 = 1'b1; #1; check("stop_clk0_ign", s_clk, 1'b1);
        b0 = 1'b0;
        bsel = 1'b0; #30;
        check("stop_sel_hold", s_sel, 1'b1);
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("resume_edge1", s_sel, 1'b1);
        @(posedge clk); #1;
        check("resume_edge2", s_sel, 1'b0);
        b0 = 1'b1; #1; check("resume_clk0_hi", s_clk, 1'b1);
        b0 = 1'b0; #1; check("resume_clk0_lo", s_clk, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
